// File: rtl/memory_interface.sv
// Byte-addressed 256x8 memory behind a MOV/MOC handshake with a fixed access latency.
// Word accesses are big-endian and 4-byte aligned; byte reads are zero-extended.
module memory_interface #(
    parameter int unsigned LATENCY = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MOV,
    input  logic        RW,
    input  logic        BYTE,
    input  logic [7:0]  address,
    input  logic [31:0] data_in,
    output logic [31:0] data_out,
    output logic        MOC
);

    typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

    localparam logic [3:0] CntLoad = 4'(LATENCY - 1);

    state_e      r_state;
    state_e      w_state_next;
    logic [3:0]  r_cnt;
    logic [3:0]  w_cnt_next;
    logic        r_moc;
    logic        w_moc_next;
    logic        w_capture;
    logic        w_access;
    logic        w_wr_en;

    logic [7:0]  r_addr;
    logic        r_rw;
    logic        r_byte;
    logic [31:0] r_wdata;
    logic [31:0] r_data_out;

    logic [7:0]  r_mem [256];

    logic [7:0]  w_base0;
    logic [7:0]  w_base1;
    logic [7:0]  w_base2;
    logic [7:0]  w_base3;

    // Word accesses force address bits 1:0 to zero, so no wrap past byte 255.
    assign w_base0 = {r_addr[7:2], 2'b00};
    assign w_base1 = {r_addr[7:2], 2'b01};
    assign w_base2 = {r_addr[7:2], 2'b10};
    assign w_base3 = {r_addr[7:2], 2'b11};

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_moc_next   = 1'b0;
        w_capture    = 1'b0;
        w_access     = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (MOV) begin
                    w_capture    = 1'b1;
                    w_cnt_next   = CntLoad;
                    w_state_next = StBusy;
                end
            end
            StBusy: begin
                // Dropping MOV before completion abandons the access.
                if (!MOV) begin
                    w_cnt_next   = 4'd0;
                    w_state_next = StIdle;
                end else if (r_cnt == 4'd0) begin
                    w_access     = 1'b1;
                    w_moc_next   = 1'b1;
                    w_state_next = StDone;
                end else begin
                    w_cnt_next   = r_cnt - 4'd1;
                end
            end
            StDone: begin
                if (MOV) begin
                    w_moc_next   = 1'b1;
                end else begin
                    w_state_next = StIdle;
                end
            end
            default: begin
                w_state_next = StIdle;
            end
        endcase
    end

    assign w_wr_en = w_access && !r_rw && !reset;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= StIdle;
            r_cnt      <= 4'd0;
            r_moc      <= 1'b0;
            r_addr     <= 8'h00;
            r_rw       <= 1'b0;
            r_byte     <= 1'b0;
            r_wdata    <= 32'h0;
            r_data_out <= 32'h0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            r_moc   <= w_moc_next;
            if (w_capture) begin
                r_addr  <= address;
                r_rw    <= RW;
                r_byte  <= BYTE;
                r_wdata <= data_in;
            end
            if (w_access && r_rw) begin
                if (r_byte) begin
                    r_data_out <= {24'h0, r_mem[r_addr]};
                end else begin
                    r_data_out <= {r_mem[w_base0], r_mem[w_base1],
                                   r_mem[w_base2], r_mem[w_base3]};
                end
            end
        end
    end

    // Storage is deliberately not reset.
    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            if (r_byte) begin
                r_mem[r_addr] <= r_wdata[7:0];
            end else begin
                r_mem[w_base0] <= r_wdata[31:24];
                r_mem[w_base1] <= r_wdata[23:16];
                r_mem[w_base2] <= r_wdata[15:8];
                r_mem[w_base3] <= r_wdata[7:0];
            end
        end
    end

    assign data_out = r_data_out;
    assign MOC      = r_moc;

endmodule

// File: tb/tb_memory_interface.sv
// Bench for memory_interface: scoreboarded reads against a byte-array model, plus
// latency checks on LATENCY=1, 2 and 15 instances sharing the same stimulus.
module tb_memory_interface;

    logic        clk = 1'b0;
    logic        reset;
    logic        MOV;
    logic        RW;
    logic        BYTE;
    logic [7:0]  address;
    logic [31:0] data_in;
    logic [31:0] data_out, data_out_l1, data_out_l15;
    logic        MOC, moc_l1, moc_l15;

    int checks = 0;
    int errors = 0;

    logic [7:0]  m_mem [256];
    logic [31:0] sb [$];

    always #5 clk = ~clk;

    memory_interface #(.LATENCY(2)) dut (
        .clk(clk), .reset(reset), .MOV(MOV), .RW(RW), .BYTE(BYTE),
        .address(address), .data_in(data_in), .data_out(data_out), .MOC(MOC)
    );

    memory_interface #(.LATENCY(1)) dut_l1 (
        .clk(clk), .reset(reset), .MOV(MOV), .RW(RW), .BYTE(BYTE),
        .address(address), .data_in(data_in), .data_out(data_out_l1), .MOC(moc_l1)
    );

    memory_interface #(.LATENCY(15)) dut_l15 (
        .clk(clk), .reset(reset), .MOV(MOV), .RW(RW), .BYTE(BYTE),
        .address(address), .data_in(data_in), .data_out(data_out_l15), .MOC(moc_l15)
    );

    function automatic logic [31:0] model_read(input logic [7:0] a, input logic bt);
        logic [7:0] b;
        b = {a[7:2], 2'b00};
        if (bt) return {24'h0, m_mem[a]};
        return {m_mem[b], m_mem[b + 8'd1], m_mem[b + 8'd2], m_mem[b + 8'd3]};
    endfunction

    function automatic void model_write(input logic [7:0] a, input logic bt,
                                        input logic [31:0] d);
        logic [7:0] b;
        b = {a[7:2], 2'b00};
        if (bt) begin
            m_mem[a] = d[7:0];
        end else begin
            m_mem[b]        = d[31:24];
            m_mem[b + 8'd1] = d[23:16];
            m_mem[b + 8'd2] = d[15:8];
            m_mem[b + 8'd3] = d[7:0];
        end
    endfunction

    // Full handshake on the LATENCY=2 instance; inputs are scrambled after acceptance.
    task automatic do_op(input logic rw, input logic bt, input logic [7:0] a,
                         input logic [31:0] d);
        int n;
        logic [31:0] exp;
        @(negedge clk);
        MOV = 1'b1; RW = rw; BYTE = bt; address = a; data_in = d;
        if (rw) sb.push_back(model_read(a, bt));
        else model_write(a, bt, d);
        @(posedge clk);
        @(negedge clk);
        RW = ~rw; BYTE = ~bt; address = ~a; data_in = ~d;
        n = 0;
        while (n < 8) begin
            @(posedge clk); #1;
            n++;
            if (MOC === 1'b1) break;
        end
        checks++;
        if (MOC !== 1'b1 || n != 2) begin
            $display("FAIL op_latency addr=%h: MOC=%b after %0d edges, required 1 after 2",
                     a, MOC, n);
            errors++;
        end
        if (rw) begin
            exp = sb.pop_front();
            checks++;
            if (data_out !== exp) begin
                $display("FAIL read_data addr=%h byte=%b: got %h, required %h",
                         a, bt, data_out, exp);
                errors++;
            end
        end
        @(negedge clk);
        MOV = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (MOC !== 1'b0) begin
            $display("FAIL moc_release: MOC=%b, required 0", MOC);
            errors++;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; MOV = 1'b0; RW = 1'b0; BYTE = 1'b0; address = 8'h0; data_in = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (data_out !== 32'h0 || MOC !== 1'b0) begin
            $display("FAIL reset_state: data_out=%h MOC=%b, required 00000000 and 0",
                     data_out, MOC);
            errors++;
        end
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            checks++;
            if (MOC !== 1'b0) begin
                $display("FAIL idle_moc edge %0d: MOC=%b, required 0", i, MOC);
                errors++;
            end
        end
    endtask

    task automatic test_word();
        do_op(1'b0, 1'b0, 8'h10, 32'hDEADBEEF);
        do_op(1'b1, 1'b0, 8'h12, 32'h0);
    endtask

    task automatic test_byte();
        do_op(1'b1, 1'b1, 8'h11, 32'h0);
        do_op(1'b0, 1'b1, 8'h13, 32'hFFFFFF55);
        checks++;
        if (data_out !== 32'h000000AD) begin
            $display("FAIL hold_through_write: data_out=%h, required 000000ad", data_out);
            errors++;
        end
        do_op(1'b1, 1'b0, 8'h10, 32'h0);
    endtask

    task automatic test_abort();
        logic [31:0] held;
        do_op(1'b0, 1'b0, 8'h20, 32'hCAFEF00D);
        held = data_out;
        @(negedge clk);
        MOV = 1'b1; RW = 1'b0; BYTE = 1'b0; address = 8'h20; data_in = 32'h12345678;
        @(posedge clk);
        @(negedge clk);
        MOV = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            checks++;
            if (MOC !== 1'b0 || data_out !== held) begin
                $display("FAIL abort edge %0d: MOC=%b data_out=%h, required 0 and %h",
                         i, MOC, data_out, held);
                errors++;
            end
        end
        do_op(1'b1, 1'b0, 8'h20, 32'h0);
    endtask

    task automatic test_reset_busy();
        @(negedge clk);
        MOV = 1'b1; RW = 1'b0; BYTE = 1'b0; address = 8'h20; data_in = 32'h11223344;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0; MOV = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            checks++;
            if (MOC !== 1'b0 || data_out !== 32'h0) begin
                $display("FAIL reset_busy edge %0d: MOC=%b data_out=%h, required 0 and 0",
                         i, MOC, data_out);
                errors++;
            end
        end
        do_op(1'b1, 1'b1, 8'h20, 32'h0);
    endtask

    // All three instances accept on the same edge; each MOC must rise at its own latency.
    task automatic test_handshake();
        logic [2:0] got, want;
        @(negedge clk);
        MOV = 1'b1; RW = 1'b0; BYTE = 1'b0; address = 8'h30; data_in = 32'hA5A55A5A;
        model_write(8'h30, 1'b0, 32'hA5A55A5A);
        @(posedge clk);
        for (int e = 1; e <= 21; e++) begin
            @(posedge clk); #1;
            got  = {moc_l15, MOC, moc_l1};
            want = {e >= 15, e >= 2, e >= 1};
            checks++;
            if (got !== want) begin
                $display("FAIL hold_moc edge %0d: {L15,L2,L1}=%b, required %b", e, got, want);
                errors++;
            end
        end
        @(negedge clk);
        MOV = 1'b0;
        @(posedge clk); #1;
        got = {moc_l15, MOC, moc_l1};
        checks++;
        if (got !== 3'b000) begin
            $display("FAIL hold_release: {L15,L2,L1}=%b, required 000", got);
            errors++;
        end
        do_op(1'b1, 1'b0, 8'h30, 32'h0);
    endtask

    initial begin
        test_reset();
        test_word();
        test_byte();
        test_abort();
        test_reset_busy();
        test_handshake();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
